// File: rtl/sdram_ctrl_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdram_ctrl_arb_pkg
//   Shared definitions for the SDRAM slave-port arbiter: bus widths, FSM state
//   encodings, FLUSH length and a helper for index widths.
//   The bus-width macros SDRAM_ADR_WIDTH / WB_DATA_WIDTH / WB_SEL_WIDTH are
//   normally provided by i2d_soc_defines.v; defaults are supplied here when
//   that file has not been read first.
//   Optional feature macro: SDRAM_ARB_TMO_EN (watchdog + FLUSH state).
// ---------------------------------------------------------------------------
`ifndef SDRAM_ADR_WIDTH
`define SDRAM_ADR_WIDTH 24
`endif
`ifndef WB_DATA_WIDTH
`define WB_DATA_WIDTH 32
`endif
`ifndef WB_SEL_WIDTH
`define WB_SEL_WIDTH 4
`endif

package sdram_ctrl_arb_pkg;

    localparam int SDRAM_ADR_W = `SDRAM_ADR_WIDTH;
    localparam int WB_DATA_W   = `WB_DATA_WIDTH;
    localparam int WB_SEL_W    = `WB_SEL_WIDTH;

    typedef enum logic [1:0] {
        SDRAM_ARB_IDLE  = 2'd0,
        SDRAM_ARB_GRANT = 2'd1,
        SDRAM_ARB_FLUSH = 2'd2
    } arb_state_e;

`ifdef SDRAM_ARB_TMO_EN
    // Cycles spent in FLUSH after a watchdog timeout.
    localparam int SDRAM_ARB_FLUSH_LEN = 16;
    localparam int SDRAM_ARB_FLUSH_W   = $clog2(SDRAM_ARB_FLUSH_LEN);
`endif

    // Width of a master index; never zero so NM=1 still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_ctrl_arb_rr.sv
// ---------------------------------------------------------------------------
// sdram_ctrl_arb_rr
//   Combinational round-robin picker. Searches ptr+1, ptr+2, ... (mod NM) and
//   returns the first requester.
//   Ports:
//     i_req  [NM]   request vector (cyc & stb per master)
//     i_ptr  [IW]   index of the master served last
//     o_gnt  [NM]   one-hot winner (zero when nobody requests)
//     o_idx  [IW]   winner index
//     o_any         at least one request present
// ---------------------------------------------------------------------------
module sdram_ctrl_arb_rr
    import sdram_ctrl_arb_pkg::*;
#(
    parameter int NM = 3
) (
    input  logic [NM-1:0]               i_req,
    input  logic [idx_width(NM)-1:0]    i_ptr,
    output logic [NM-1:0]               o_gnt,
    output logic [idx_width(NM)-1:0]    o_idx,
    output logic                        o_any
);

    localparam int IW = idx_width(NM);

    int w_cand;

    // Offset NM wraps back to ptr itself, so the last-served master is only
    // chosen again when it is the sole requester.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = 0;
        for (int i = 1; i <= NM; i++) begin
            w_cand = (int'(i_ptr) + i) % NM;
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/sdram_ctrl_arb.sv
// ---------------------------------------------------------------------------
// sdram_ctrl_arb
//   Wishbone arbiter sharing the single sdram_ctrl slave port between NM
//   masters. Round-robin grant, held for a whole cyc tenure.
//   Optional macro SDRAM_ARB_TMO_EN: response watchdog (TMO_W/TMO_MAX),
//   forced error and a FLUSH state that swallows late slave responses.
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     m_adr_i/m_dat_i/m_sel_i      packed per-master request fields
//     m_we_i/m_cyc_i/m_stb_i       per-master controls
//     m_dat_o                      slave read data broadcast to all masters
//     m_ack_o/m_err_o/m_rty_o      responses, granted master bit only
//     s_*_o / s_*_i                sdram_ctrl slave port
//     gnt_o                        registered one-hot grant
// ---------------------------------------------------------------------------
module sdram_ctrl_arb
    import sdram_ctrl_arb_pkg::*;
#(
    parameter int NM = 3
`ifdef SDRAM_ARB_TMO_EN
    ,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NM*SDRAM_ADR_W-1:0]   m_adr_i,
    input  logic [NM*WB_DATA_W-1:0]     m_dat_i,
    input  logic [NM*WB_SEL_W-1:0]      m_sel_i,
    input  logic [NM-1:0]               m_we_i,
    input  logic [NM-1:0]               m_cyc_i,
    input  logic [NM-1:0]               m_stb_i,
    output logic [WB_DATA_W-1:0]        m_dat_o,
    output logic [NM-1:0]               m_ack_o,
    output logic [NM-1:0]               m_err_o,
    output logic [NM-1:0]               m_rty_o,
    output logic [SDRAM_ADR_W-1:0]      s_adr_o,
    output logic [WB_DATA_W-1:0]        s_dat_o,
    output logic [WB_SEL_W-1:0]         s_sel_o,
    output logic                        s_we_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    input  logic [WB_DATA_W-1:0]        s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    input  logic                        s_rty_i,
    output logic [NM-1:0]               gnt_o
);

    localparam int IW = idx_width(NM);

    arb_state_e             r_state;
    arb_state_e             w_state_next;
    logic [NM-1:0]          r_gnt;
    logic [IW-1:0]          r_ptr;      // last granted master; mux select while in GRANT

    logic [NM-1:0]          w_req;
    logic [NM-1:0]          w_rr_gnt;
    logic [IW-1:0]          w_rr_idx;
    logic                   w_rr_any;
    logic                   w_cyc_k;
    logic                   w_stb_k;
    logic                   w_tmo;

    logic [SDRAM_ADR_W-1:0] w_adr [NM];
    logic [WB_DATA_W-1:0]   w_dat [NM];
    logic [WB_SEL_W-1:0]    w_sel [NM];

    genvar gi;
    generate
        for (gi = 0; gi < NM; gi++) begin : g_unpack
            assign w_req[gi] = m_cyc_i[gi] & m_stb_i[gi];
            assign w_adr[gi] = m_adr_i[gi*SDRAM_ADR_W +: SDRAM_ADR_W];
            assign w_dat[gi] = m_dat_i[gi*WB_DATA_W +: WB_DATA_W];
            assign w_sel[gi] = m_sel_i[gi*WB_SEL_W +: WB_SEL_W];
        end
    endgenerate

    assign w_cyc_k = m_cyc_i[r_ptr];
    assign w_stb_k = m_stb_i[r_ptr];

    sdram_ctrl_arb_rr #(
        .NM (NM)
    ) u_rr (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

`ifdef SDRAM_ARB_TMO_EN
    logic [TMO_W-1:0]             r_tmo_cnt;
    logic [SDRAM_ARB_FLUSH_W-1:0] r_flush_cnt;

    assign w_tmo = (r_state == SDRAM_ARB_GRANT) && (r_tmo_cnt == TMO_W'(TMO_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt   <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_state != SDRAM_ARB_GRANT || !w_stb_k || s_ack_i || s_err_i || s_rty_i)
                r_tmo_cnt <= '0;
            else if (r_tmo_cnt != TMO_W'(TMO_MAX))
                r_tmo_cnt <= r_tmo_cnt + 1'b1;

            if (r_state == SDRAM_ARB_FLUSH)
                r_flush_cnt <= r_flush_cnt + 1'b1;
            else
                r_flush_cnt <= '0;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    // State register plus the grant/pointer bookkeeping tied to transitions.
    // On a timeout ptr already holds the offender, so the next search skips it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SDRAM_ARB_IDLE;
            r_gnt   <= '0;
            r_ptr   <= IW'(NM - 1);
        end else begin
            r_state <= w_state_next;
            case (r_state)
                SDRAM_ARB_IDLE: begin
                    if (w_rr_any) begin
                        r_gnt <= w_rr_gnt;
                        r_ptr <= w_rr_idx;
                    end
                end
                SDRAM_ARB_GRANT: begin
                    if (!w_cyc_k || w_tmo)
                        r_gnt <= '0;
                end
                default: r_gnt <= '0;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SDRAM_ARB_IDLE: begin
                if (w_rr_any)
                    w_state_next = SDRAM_ARB_GRANT;
            end
            SDRAM_ARB_GRANT: begin
`ifdef SDRAM_ARB_TMO_EN
                if (w_tmo)
                    w_state_next = SDRAM_ARB_FLUSH;
                else
`endif
                if (!w_cyc_k)
                    w_state_next = SDRAM_ARB_IDLE;
            end
`ifdef SDRAM_ARB_TMO_EN
            SDRAM_ARB_FLUSH: begin
                if (r_flush_cnt == SDRAM_ARB_FLUSH_W'(SDRAM_ARB_FLUSH_LEN - 1))
                    w_state_next = SDRAM_ARB_IDLE;
            end
`endif
            default: w_state_next = SDRAM_ARB_IDLE;
        endcase
    end

    // Slave side is a live mux of the granted master so a dropped cyc reaches
    // the slave in the same cycle; responses are only passed while in GRANT.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (r_state == SDRAM_ARB_GRANT) begin
            s_adr_o = w_adr[r_ptr];
            s_dat_o = w_dat[r_ptr];
            s_sel_o = w_sel[r_ptr];
            s_we_o  = m_we_i[r_ptr];
            s_cyc_o = w_cyc_k & ~w_tmo;
            s_stb_o = w_stb_k & ~w_tmo;
            m_ack_o = r_gnt & {NM{s_ack_i & ~w_tmo}};
            m_err_o = r_gnt & {NM{s_err_i | w_tmo}};
            m_rty_o = r_gnt & {NM{s_rty_i & ~w_tmo}};
        end
    end

    assign m_dat_o = s_dat_i;
    assign gnt_o   = r_gnt;

endmodule

// File: tb/tb_sdram_ctrl_arb.sv
module tb_sdram_ctrl_arb;
    import sdram_ctrl_arb_pkg::*;

    localparam int NM = 3;

    logic                       clk;
    logic                       rst;
    logic [NM*SDRAM_ADR_W-1:0]  m_adr_i;
    logic [NM*WB_DATA_W-1:0]    m_dat_i;
    logic [NM*WB_SEL_W-1:0]     m_sel_i;
    logic [NM-1:0]              m_we_i;
    logic [NM-1:0]              m_cyc_i;
    logic [NM-1:0]              m_stb_i;
    logic [WB_DATA_W-1:0]       m_dat_o;
    logic [NM-1:0]              m_ack_o;
    logic [NM-1:0]              m_err_o;
    logic [NM-1:0]              m_rty_o;
    logic [SDRAM_ADR_W-1:0]     s_adr_o;
    logic [WB_DATA_W-1:0]       s_dat_o;
    logic [WB_SEL_W-1:0]        s_sel_o;
    logic                       s_we_o;
    logic                       s_cyc_o;
    logic                       s_stb_o;
    logic [WB_DATA_W-1:0]       s_dat_i;
    logic                       s_ack_i;
    logic                       s_err_i;
    logic                       s_rty_i;
    logic [NM-1:0]              gnt_o;

    sdram_ctrl_arb #(.NM(NM)) dut (
        .clk     (clk),
        .rst     (rst),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_we_i  (m_we_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_rty_o (m_rty_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .s_rty_i (s_rty_i),
        .gnt_o   (gnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = one clock of stimulus plus the outputs expected in that clock.
    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] we;
        logic       ack;
        logic       err;
        logic       rty;
        logic [2:0] e_gnt;
        logic       e_cyc;
        logic [2:0] e_ack;
        logic [2:0] e_err;
        logic [2:0] e_rty;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    logic [SDRAM_ADR_W-1:0] madr [NM];
    logic [WB_DATA_W-1:0]   mdat [NM];
    logic [WB_SEL_W-1:0]    msel [NM];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] req, input logic [2:0] we,
                       input logic ack, input logic err, input logic rty,
                       input logic [2:0] eg, input logic ec, input logic [2:0] ea,
                       input logic [2:0] ee, input logic [2:0] er);
        vec_t v;
        v.rst = r; v.req = req; v.we = we; v.ack = ack; v.err = err; v.rty = rty;
        v.e_gnt = eg; v.e_cyc = ec; v.e_ack = ea; v.e_err = ee; v.e_rty = er;
        vecs.push_back(v);
    endtask

    task automatic add_round3();
        add(0, 3'b111, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        add(0, 3'b111, 0, 1, 0, 0, 3'b001, 1, 3'b001, 0, 0);
        add(0, 3'b110, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
        add(0, 3'b110, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        add(0, 3'b110, 0, 1, 0, 0, 3'b010, 1, 3'b010, 0, 0);
        add(0, 3'b100, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0);
        add(0, 3'b100, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        add(0, 3'b100, 0, 1, 0, 0, 3'b100, 1, 3'b100, 0, 0);
        add(0, 3'b000, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    endtask

    task automatic drive_idle();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t v;
        vec_t e;
        int   k;
        int   n;
        logic ok;

        madr[0] = 'h100; madr[1] = 'h200; madr[2] = 'h300;
        mdat[0] = 32'hDEADBEEF; mdat[1] = 32'h1111_1111; mdat[2] = 32'h2222_2222;
        msel[0] = 4'b0011; msel[1] = 4'b1111; msel[2] = 4'b1100;

        // reset state, single read from master 0, then reset
        add(0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        add(0, 3'b001, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        add(0, 3'b001, 0, 1, 0, 0, 3'b001, 1, 3'b001, 0, 0);
        add(0, 3'b000, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
        add(1, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        // all three at once, twice: 0,1,2 each time
        add_round3();
        add_round3();
        // master 1 4-beat burst while master 2 waits; master 2 then gets an error
        add(0, 3'b010, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        add(0, 3'b110, 0, 1, 0, 0, 3'b010, 1, 3'b010, 0, 0);
        add(0, 3'b110, 0, 1, 0, 0, 3'b010, 1, 3'b010, 0, 0);
        add(0, 3'b110, 0, 1, 0, 0, 3'b010, 1, 3'b010, 0, 0);
        add(0, 3'b110, 0, 1, 0, 0, 3'b010, 1, 3'b010, 0, 0);
        add(0, 3'b100, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0);
        add(0, 3'b100, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        add(0, 3'b100, 0, 0, 1, 0, 3'b100, 1, 0, 3'b100, 0);
        // reset during master 2's tenure; master 0 wins first afterwards (write)
        add(1, 3'b101, 0, 0, 0, 0, 3'b100, 1, 0, 0, 0);
        add(0, 3'b101, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        add(0, 3'b101, 3'b001, 1, 0, 0, 3'b001, 1, 3'b001, 0, 0);
        add(0, 3'b100, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
        add(0, 3'b100, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        add(0, 3'b100, 0, 0, 0, 1, 3'b100, 1, 0, 0, 3'b100);
        add(0, 3'b000, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0);
        add(0, 3'b000, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);

        m_adr_i = {madr[2], madr[1], madr[0]};
        m_dat_i = {mdat[2], mdat[1], mdat[0]};
        m_sel_i = {msel[2], msel[1], msel[0]};
        s_dat_i = '0;
        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            v = vecs[i];
            rst     = v.rst;
            m_cyc_i = v.req;
            m_stb_i = v.req;
            m_we_i  = v.we;
            s_ack_i = v.ack;
            s_err_i = v.err;
            s_rty_i = v.rty;
            s_dat_i = 32'hA000_0000 | WB_DATA_W'(i);
            sb.push_back(v);
            @(negedge clk);
            e = sb.pop_front();
            k = -1;
            for (int j = 0; j < NM; j++) if (e.e_gnt[j]) k = j;
            chk("gnt", i, gnt_o, e.e_gnt);
            chk("s_cyc", i, s_cyc_o, e.e_cyc);
            chk("s_stb", i, s_stb_o, e.e_cyc);
            chk("s_adr", i, s_adr_o, (k >= 0) ? madr[k] : '0);
            chk("s_dat", i, s_dat_o, (k >= 0) ? mdat[k] : '0);
            chk("s_sel", i, s_sel_o, (k >= 0) ? msel[k] : '0);
            chk("s_we", i, s_we_o, (k >= 0) ? e.we[k] : 1'b0);
            chk("m_ack", i, m_ack_o, e.e_ack);
            chk("m_err", i, m_err_o, e.e_err);
            chk("m_rty", i, m_rty_o, e.e_rty);
            chk("m_dat", i, m_dat_o, 32'hA000_0000 | WB_DATA_W'(i));
            $display("row %0d rst=%0b req=%b ack=%0b gnt=%b s_cyc=%0b m_ack=%b",
                     i, e.rst, e.req, e.ack, gnt_o, s_cyc_o, m_ack_o);
        end

`ifdef SDRAM_ARB_TMO_EN
        // Hung slave: error after exactly TMO_MAX cycles, late ack swallowed
        // during FLUSH, next master served afterwards.
        @(posedge clk); #1;
        drive_idle();
        m_cyc_i = 3'b001; m_stb_i = 3'b001;
        n = 0;
        @(negedge clk);
        while (n < 10 && gnt_o !== 3'b001) begin @(negedge clk); n++; end
        chk("tmo_grant", 0, gnt_o, 3'b001);
        n = 0;
        while (n < 300 && m_err_o !== 3'b001) begin @(negedge clk); n++; end
        chk("tmo_cycles", 0, n, 200);
        chk("tmo_s_cyc", 0, s_cyc_o, 1'b0);
        @(posedge clk); #1;
        m_cyc_i = 3'b010; m_stb_i = 3'b010; s_ack_i = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (m_ack_o !== 3'b000 || m_err_o !== 3'b000 || gnt_o !== 3'b000 || s_cyc_o !== 1'b0) ok = 1'b0;
        end
        chk("tmo_flush_quiet", 0, ok, 1'b1);
        @(posedge clk); #1;
        s_ack_i = 1'b0;
        n = 0;
        while (n < 30 && gnt_o !== 3'b010) begin @(negedge clk); n++; end
        chk("tmo_next_master", 0, gnt_o, 3'b010);
        $display("tmo sequence: next grant gnt=%b", gnt_o);
`else
        // Hung slave without watchdog: grant held, no error, other master starved.
        @(posedge clk); #1;
        drive_idle();
        m_cyc_i = 3'b010; m_stb_i = 3'b010;
        n = 0;
        @(negedge clk);
        while (n < 10 && gnt_o !== 3'b010) begin @(negedge clk); n++; end
        chk("hung_grant", 0, gnt_o, 3'b010);
        @(posedge clk); #1;
        m_cyc_i = 3'b011; m_stb_i = 3'b011;
        ok = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (gnt_o !== 3'b010 || m_err_o !== 3'b000 || m_ack_o !== 3'b000 || s_stb_o !== 1'b1) ok = 1'b0;
        end
        chk("hung_hold", 0, ok, 1'b1);
        @(posedge clk); #1;
        m_cyc_i = 3'b001; m_stb_i = 3'b001;
        n = 0;
        @(negedge clk);
        while (n < 10 && gnt_o !== 3'b001) begin @(negedge clk); n++; end
        chk("hung_release", 0, gnt_o, 3'b001);
        $display("hung sequence: after release gnt=%b", gnt_o);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
